// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift/rotate register unit.
//   - 4-bit function codes (HOLD..ROL, 1xxx is illegal)
//   - FSM state encoding (IDLE / SHIFT)
//   - helpers that classify a function code
package shift_reg_pkg;

  localparam logic [3:0] FN_HOLD  = 4'b0000;
  localparam logic [3:0] FN_LOAD  = 4'b0001;
  localparam logic [3:0] FN_CLEAR = 4'b0010;
  localparam logic [3:0] FN_SHR   = 4'b0011;
  localparam logic [3:0] FN_SHL   = 4'b0100;
  localparam logic [3:0] FN_ASR   = 4'b0101;
  localparam logic [3:0] FN_ROR   = 4'b0110;
  localparam logic [3:0] FN_ROL   = 4'b0111;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  // Codes 0011..0111 move bits; everything else in 0xxx acts in one edge.
  function automatic logic fn_is_shift(input logic [3:0] f);
    return (f[3] == 1'b0) && (f[2:0] >= 3'd3);
  endfunction

  // Steps that push a bit off the end (rotates keep every bit).
  function automatic logic fn_spills(input logic [3:0] f);
    return (f == FN_SHR) || (f == FN_SHL) || (f == FN_ASR);
  endfunction

endpackage

// File: rtl/shift_reg_step.sv
// One-bit step of the register for a given operation.
//   i_op   : function code (non-shift codes pass i_d through)
//   i_d    : current register value
//   i_fill : fill bit used by SHR/SHL
//   o_q    : value after one step
module shift_reg_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_q
);

  always_comb begin
    o_q = i_d;
    case (i_op)
      FN_SHR:  o_q = {i_fill,        i_d[WIDTH-1:1]};
      FN_SHL:  o_q = {i_d[WIDTH-2:0], i_fill};
      FN_ASR:  o_q = {i_d[WIDTH-1],   i_d[WIDTH-1:1]};
      FN_ROR:  o_q = {i_d[0],         i_d[WIDTH-1:1]};
      FN_ROL:  o_q = {i_d[WIDTH-2:0], i_d[WIDTH-1]};
      default: o_q = i_d;
    endcase
  end

endmodule

// File: rtl/shift_reg_unit.sv
// Multi-mode register: hold/load/clear plus logical, arithmetic and rotate
// shifts, one bit per clock under a start/busy/done handshake.
//   clock, reset_n    : clock, async active-low reset
//   start/func/shamt  : command strobe, op code, shift count (sampled when idle)
//   in                : load data
//   out               : register contents
//   busy              : multi-cycle shift in progress
//   done / err        : one-cycle pulses (completed / illegal code rejected)
// Optional macro SHIFT_REG_SERIAL_EN adds serial_in (SHR/SHL fill bit) and
// serial_out (last bit spilled by SHR/SHL/ASR).
module shift_reg_unit
  import shift_reg_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [3:0]         func,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   in,
  output logic [WIDTH-1:0]   out,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef SHIFT_REG_SERIAL_EN
  ,
  input  logic               serial_in,
  output logic               serial_out
`endif
);

  state_e             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_out,   w_out_nxt;
  logic [SHAMT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [3:0]         r_op,    w_op_nxt;
  logic               r_busy,  w_busy_nxt;
  logic               r_done,  w_done_nxt;
  logic               r_err,   w_err_nxt;

  logic [3:0]         w_step_op;
  logic [WIDTH-1:0]   w_step_q;
  logic               w_fill;

  // One stepper serves both states: idle uses the incoming code for the
  // first step, SHIFT uses the latched one.
  assign w_step_op = (r_state == S_SHIFT) ? r_op : func;

`ifdef SHIFT_REG_SERIAL_EN
  assign w_fill = serial_in;
`else
  assign w_fill = 1'b0;
`endif

  shift_reg_step #(.WIDTH(WIDTH)) u_step (
    .i_op   (w_step_op),
    .i_d    (r_out),
    .i_fill (w_fill),
    .o_q    (w_step_q)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (func[3]) begin
            w_err_nxt = 1'b1;
          end else if (fn_is_shift(func)) begin
            w_out_nxt = (shamt == '0) ? r_out : w_step_q;
            if (shamt > SHAMT_W'(1)) begin
              // first step already taken this edge
              w_cnt_nxt   = shamt - SHAMT_W'(1);
              w_op_nxt    = func;
              w_busy_nxt  = 1'b1;
              w_state_nxt = S_SHIFT;
            end else begin
              w_done_nxt = 1'b1;
            end
          end else begin
            case (func)
              FN_LOAD:  w_out_nxt = in;
              FN_CLEAR: w_out_nxt = '0;
              default:  w_out_nxt = r_out;
            endcase
            w_done_nxt = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        w_out_nxt = w_step_q;
        if (r_cnt == SHAMT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt  = r_cnt - SHAMT_W'(1);
          w_busy_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_cnt   <= '0;
      r_op    <= FN_HOLD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

`ifdef SHIFT_REG_SERIAL_EN
  logic w_step_en;
  logic r_sout;

  // A step happens on every SHIFT edge, and on the accepting edge of a
  // shift with a non-zero count.
  assign w_step_en = (r_state == S_SHIFT) ||
                     (start && fn_is_shift(func) && (shamt != '0));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sout <= 1'b0;
    end else if (w_step_en && fn_spills(w_step_op)) begin
      r_sout <= (w_step_op == FN_SHL) ? r_out[WIDTH-1] : r_out[0];
    end
  end

  assign serial_out = r_sout;
`endif

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule
